// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC control-flow sequencer.
// Address and opcode widths are fixed here so every user agrees on addr_t.
package pc_ctrl_pkg;

    localparam int ADDR_W = 6;
    localparam int OP_W   = 4;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OP_W-1:0] OP_JMP  = 4'd1;
    localparam logic [OP_W-1:0] OP_BEQZ = 4'd2;
    localparam logic [OP_W-1:0] OP_BNEZ = 4'd3;
    localparam logic [OP_W-1:0] OP_CALL = 4'd4;
    localparam logic [OP_W-1:0] OP_RET  = 4'd5;
    localparam logic [OP_W-1:0] OP_HALT = 4'd6;

    typedef enum logic [1:0] {
        BOOT,
        FLUSH,
        RUN,
        HALT
    } state_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO; push and pop are ignored when full or empty respectively.
// Synchronous active-low clear empties the stack.
module ret_stack
    import pc_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clock,
    input  logic  clear_n,
    input  logic  push,
    input  logic  pop,
    input  addr_t push_data,
    output logic  full,
    output logic  empty,
    output addr_t top
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    addr_t            mem_q [DEPTH];
    addr_t            mem_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign top   = empty ? '0 : mem_q[PTR_W'(count_q - CNT_W'(1))];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[PTR_W'(count_q)] = push_data;
            count_d                = count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entries beyond the count are don't-care, so storage needs no reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_controller.sv
// Control-flow sequencer driving the PC jump-load port, squashing wrong-path fetches.
// Optional return-address stack enabled by defining RET_STACK_EN.
module pc_controller
    import pc_ctrl_pkg::*;
#(
    parameter int FLUSH_CYC = 2
`ifdef RET_STACK_EN
    ,
    parameter int RET_DEPTH = 4
`endif
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              instr_valid,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic [OP_W-1:0]   opcode,
    input  logic [ADDR_W-1:0] target,
    input  logic              zero_flag,
    output logic              pc_write,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              halted,
    output logic              stack_err
);

    localparam int CNT_W = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             pc_write_q,  pc_write_d;
    addr_t            pc_target_q, pc_target_d;
    logic             flush_q,     flush_d;
    logic             halted_q,    halted_d;

    logic  redirect;
    logic  go_halt;
    addr_t redirect_addr;

`ifdef RET_STACK_EN
    logic  stack_err_q, stack_err_d;
    logic  push, pop;
    logic  stack_full, stack_empty;
    addr_t stack_top;
    addr_t push_addr;

    assign push_addr = instr_addr + addr_t'(1);

    ret_stack #(
        .DEPTH(RET_DEPTH)
    ) u_ret_stack (
        .clock    (clock),
        .clear_n  (clear_n),
        .push     (push),
        .pop      (pop),
        .push_data(push_addr),
        .full     (stack_full),
        .empty    (stack_empty),
        .top      (stack_top)
    );

    assign stack_err = stack_err_q;
`else
    assign stack_err = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write_d    = 1'b0;
        pc_target_d   = pc_target_q;
        flush_d       = flush_q;
        halted_d      = halted_q;
        redirect      = 1'b0;
        go_halt       = 1'b0;
        redirect_addr = target;
`ifdef RET_STACK_EN
        stack_err_d   = stack_err_q;
        push          = 1'b0;
        pop           = 1'b0;
`endif

        case (state_q)
            BOOT: begin
                state_d     = FLUSH;
                pc_write_d  = 1'b1;
                pc_target_d = '0;
                cnt_d       = CNT_W'(FLUSH_CYC);
                flush_d     = 1'b1;
            end
            FLUSH: begin
                flush_d = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                    flush_d = 1'b0;
                end
            end
            RUN: begin
                flush_d = 1'b0;
                if (instr_valid) begin
                    case (opcode)
                        OP_NOP:  ;
                        OP_JMP:  redirect = 1'b1;
                        OP_BEQZ: redirect = zero_flag;
                        OP_BNEZ: redirect = !zero_flag;
                        OP_HALT: go_halt  = 1'b1;
`ifdef RET_STACK_EN
                        // A full stack drops the push but the call still jumps.
                        OP_CALL: begin
                            redirect = 1'b1;
                            push     = !stack_full;
                            if (stack_full) begin
                                stack_err_d = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                go_halt     = 1'b1;
                                stack_err_d = 1'b1;
                            end else begin
                                pop           = 1'b1;
                                redirect      = 1'b1;
                                redirect_addr = stack_top;
                            end
                        end
`else
                        OP_CALL: redirect = 1'b1;
                        OP_RET:  ;
`endif
                        default: ;
                    endcase
                end

                if (go_halt) begin
                    state_d     = HALT;
                    pc_write_d  = 1'b1;
                    pc_target_d = instr_addr;
                    flush_d     = 1'b1;
                    halted_d    = 1'b1;
                end else if (redirect) begin
                    state_d     = FLUSH;
                    pc_write_d  = 1'b1;
                    pc_target_d = redirect_addr;
                    cnt_d       = CNT_W'(FLUSH_CYC);
                    flush_d     = 1'b1;
                end
            end
            HALT: begin
                pc_write_d = 1'b1;
                flush_d    = 1'b1;
                halted_d   = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q     <= BOOT;
            cnt_q       <= '0;
            pc_write_q  <= 1'b0;
            pc_target_q <= '0;
            flush_q     <= 1'b1;
            halted_q    <= 1'b0;
`ifdef RET_STACK_EN
            stack_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_write_q  <= pc_write_d;
            pc_target_q <= pc_target_d;
            flush_q     <= flush_d;
            halted_q    <= halted_d;
`ifdef RET_STACK_EN
            stack_err_q <= stack_err_d;
`endif
        end
    end

    assign pc_write  = pc_write_q;
    assign pc_target = pc_target_q;
    assign flush     = flush_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_pc_controller.sv
// Directed table-driven bench for pc_controller; expected values are hand-computed.
// Stack-specific sequences are selected by RET_STACK_EN, matching the RTL build.
module tb_pc_controller;
    import pc_ctrl_pkg::*;

    logic              clock;
    logic              clear_n;
    logic              instr_valid;
    logic [ADDR_W-1:0] instr_addr;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] target;
    logic              zero_flag;
    logic              pc_write;
    logic [ADDR_W-1:0] pc_target;
    logic              flush;
    logic              halted;
    logic              stack_err;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic       clr;
        logic       valid;
        logic [5:0] addr;
        logic [3:0] op;
        logic [5:0] tgt;
        logic       zf;
        logic       ew;
        logic [5:0] et;
        logic       ef;
        logic       eh;
        logic       ee;
    } vec_t;

    vec_t vecs[$];

    pc_controller dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .instr_valid(instr_valid),
        .instr_addr (instr_addr),
        .opcode     (opcode),
        .target     (target),
        .zero_flag  (zero_flag),
        .pc_write   (pc_write),
        .pc_target  (pc_target),
        .flush      (flush),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic addVec(input logic clr, input logic valid, input logic [5:0] addr,
                          input logic [3:0] op, input logic [5:0] tgt, input logic zf,
                          input logic ew, input logic [5:0] et, input logic ef,
                          input logic eh, input logic ee);
        vec_t v;
        v.clr = clr; v.valid = valid; v.addr = addr; v.op = op; v.tgt = tgt; v.zf = zf;
        v.ew = ew; v.et = et; v.ef = ef; v.eh = eh; v.ee = ee;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic clr, input logic valid, input logic [5:0] addr,
                                 input logic [3:0] op, input logic [5:0] tgt, input logic zf);
        clear_n     = clr;
        instr_valid = valid;
        instr_addr  = addr;
        opcode      = op;
        target      = tgt;
        zero_flag   = zf;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ew, input logic [5:0] et,
                               input logic ef, input logic eh, input logic ee);
        check_count++;
        if ({pc_write, pc_target, flush, halted, stack_err} === {ew, et, ef, eh, ee}) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got w=%0b t=%0d f=%0b h=%0b e=%0b, expected w=%0b t=%0d f=%0b h=%0b e=%0b",
                     name, pc_write, pc_target, flush, halted, stack_err, ew, et, ef, eh, ee);
        end
    endtask

    task automatic step(input string name, input logic clr, input logic valid,
                        input logic [5:0] addr, input logic [3:0] op, input logic [5:0] tgt,
                        input logic zf, input logic ew, input logic [5:0] et, input logic ef,
                        input logic eh, input logic ee);
        applyStimulus(clr, valid, addr, op, tgt, zf);
        checkOutput(name, ew, et, ef, eh, ee);
    endtask

    // Reset, boot, and the flush tail after boot, all ending in RUN with pc_target=0.
    task automatic resetAndBoot(input string name, input logic ee_in_reset);
        step({name, "_rst"},   1'b0, 1'b0, 6'd0, OP_NOP, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, ee_in_reset);
        step({name, "_boot"},  1'b1, 1'b0, 6'd0, OP_NOP, 6'd0, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0);
        step({name, "_fl"},    1'b1, 1'b0, 6'd0, OP_NOP, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        step({name, "_run"},   1'b1, 1'b0, 6'd0, OP_NOP, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 6'd0, OP_NOP, 6'd0, 1'b0);

        // clr valid addr op tgt zf | w target flush halted err
        addVec(0, 0, 0,  OP_NOP,  0,  0, 0, 0,  1, 0, 0);
        addVec(0, 0, 0,  OP_NOP,  0,  0, 0, 0,  1, 0, 0);
        addVec(0, 0, 0,  OP_NOP,  0,  0, 0, 0,  1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 1, 0,  1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 0,  1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 0,  0, 0, 0);
        addVec(1, 1, 5,  OP_JMP,  40, 0, 1, 40, 1, 0, 0);
        addVec(1, 1, 6,  OP_JMP,  50, 0, 0, 40, 1, 0, 0);
        addVec(1, 1, 7,  OP_JMP,  60, 0, 0, 40, 0, 0, 0);
        addVec(1, 1, 41, OP_BEQZ, 12, 0, 0, 40, 0, 0, 0);
        addVec(1, 1, 42, OP_NOP,  20, 1, 0, 40, 0, 0, 0);
        addVec(1, 0, 43, OP_JMP,  1,  0, 0, 40, 0, 0, 0);
        addVec(1, 1, 43, OP_BEQZ, 12, 1, 1, 12, 1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 12, 1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 12, 0, 0, 0);
        addVec(1, 1, 12, OP_BNEZ, 30, 1, 0, 12, 0, 0, 0);
        addVec(1, 1, 13, OP_BNEZ, 30, 0, 1, 30, 1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 30, 1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 30, 0, 0, 0);
        addVec(1, 1, 30, OP_JMP,  31, 0, 1, 31, 1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 31, 1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 31, 0, 0, 0);
        addVec(1, 1, 31, 4'd7,    5,  0, 0, 31, 0, 0, 0);
        addVec(1, 1, 32, 4'd15,   5,  1, 0, 31, 0, 0, 0);
        addVec(1, 1, 33, OP_HALT, 9,  0, 1, 33, 1, 1, 0);
        addVec(1, 1, 34, OP_JMP,  9,  0, 1, 33, 1, 1, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 1, 33, 1, 1, 0);
        addVec(0, 0, 0,  OP_NOP,  0,  0, 0, 0,  1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 1, 0,  1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 0,  1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 0,  0, 0, 0);
        addVec(1, 1, 2,  OP_JMP,  20, 0, 1, 20, 1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 20, 1, 0, 0);
        addVec(0, 0, 0,  OP_NOP,  0,  0, 0, 0,  1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 1, 0,  1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 0,  1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 0,  0, 0, 0);
        addVec(1, 1, 63, OP_JMP,  0,  0, 1, 0,  1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 0,  1, 0, 0);
        addVec(1, 0, 0,  OP_NOP,  0,  0, 0, 0,  0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].clr, vecs[i].valid, vecs[i].addr, vecs[i].op,
                          vecs[i].tgt, vecs[i].zf);
            checkOutput($sformatf("vec%0d", i), vecs[i].ew, vecs[i].et, vecs[i].ef,
                        vecs[i].eh, vecs[i].ee);
        end

`ifdef RET_STACK_EN
        // Call from 63 pushes the wrapped return address 0.
        step("call63",  1, 1, 63, OP_CALL, 10, 0, 1, 10, 1, 0, 0);
        step("call_f1", 1, 0, 0,  OP_NOP,  0,  0, 0, 10, 1, 0, 0);
        step("call_f2", 1, 0, 0,  OP_NOP,  0,  0, 0, 10, 0, 0, 0);
        step("ret0",    1, 1, 10, OP_RET,  33, 0, 1, 0,  1, 0, 0);
        step("ret_f1",  1, 0, 0,  OP_NOP,  0,  0, 0, 0,  1, 0, 0);
        step("ret_f2",  1, 0, 0,  OP_NOP,  0,  0, 0, 0,  0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step($sformatf("nest%0d", k), 1, 1, 6'(k), OP_CALL, 6'(k + 1), 0,
                 1, 6'(k + 1), 1, 0, (k == 5));
            step($sformatf("nest%0d_f1", k), 1, 0, 0, OP_NOP, 0, 0, 0, 6'(k + 1), 1, 0, (k == 5));
            step($sformatf("nest%0d_f2", k), 1, 0, 0, OP_NOP, 0, 0, 0, 6'(k + 1), 0, 0, (k == 5));
        end
        step("ret_top", 1, 1, 6,  OP_RET,  0,  0, 1, 5,  1, 0, 1);
        step("ret_tf1", 1, 0, 0,  OP_NOP,  0,  0, 0, 5,  1, 0, 1);
        step("ret_tf2", 1, 0, 0,  OP_NOP,  0,  0, 0, 5,  0, 0, 1);
        resetAndBoot("uflow", 1'b0);
        step("ret_empty", 1, 1, 7, OP_RET, 20, 0, 1, 7, 1, 1, 1);
        for (int k = 0; k < 4; k++) begin
            step($sformatf("uflow_hold%0d", k), 1, 1, 6'(k + 40), OP_JMP, 3, 0, 1, 7, 1, 1, 1);
        end
        resetAndBoot("after_uflow", 1'b0);
`else
        // Without the stack, CALL is a plain jump and RET falls through.
        step("call63",  1, 1, 63, OP_CALL, 10, 0, 1, 10, 1, 0, 0);
        step("call_f1", 1, 0, 0,  OP_NOP,  0,  0, 0, 10, 1, 0, 0);
        step("call_f2", 1, 0, 0,  OP_NOP,  0,  0, 0, 10, 0, 0, 0);
        step("ret_nop", 1, 1, 10, OP_RET,  33, 0, 0, 10, 0, 0, 0);
        step("ret_nop2", 1, 1, 11, OP_RET, 34, 1, 0, 10, 0, 0, 0);
`endif

        step("halt20", 1, 1, 20, OP_HALT, 50, 0, 1, 20, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            step($sformatf("halt_hold%0d", k), 1, 1, 6'(k), OP_JMP, 6'(k + 9), 1, 1, 20, 1, 1, 0);
        end
        resetAndBoot("halt_exit", 1'b0);
        step("post_jmp", 1, 1, 0, OP_JMP, 1, 0, 1, 1, 1, 0, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
